chip8_sprite_drawer: RTL and testbench
======================================

# chip8_sprite_drawer

Draw engine for the Chip-8 DXYN instruction. It is the initiator on the framebuffer's general-purpose port. On a start request it fetches N sprite bytes from main memory starting at I. It XORs each set sprite bit into the 64x32 framebuffer with a read-modify-write, and reports whether any lit pixel was cleared (collision, which the CPU writes to VF). It sits between the CPU execute stage, the main memory read port, and the framebuffer general port.

## Interface
Parameters:
- none (geometry fixed by shared package: 64x32, 8-pixel sprite rows)

Ports:
- clk  in  1  system clock; the block uses this one clock only
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle draw request; sampled only in IDLE
- x  in  6  sprite origin column (Vx mod 64)
- y  in  5  sprite origin row (Vy mod 32)
- n  in  4  sprite height in rows, 0..15
- i_addr  in  12  sprite base address (register I)
- mem_addr  out  12  main-memory read address
- mem_rd  out  1  main-memory read strobe
- mem_readdata  in  8  read data; valid the cycle after mem_rd
- fb_addr_x  out  6  framebuffer column
- fb_addr_y  out  5  framebuffer row
- fb_writedata  out  1  pixel write value
- fb_WE  out  1  framebuffer write enable
- fb_readdata  in  1  pixel read value; valid the cycle after the address is presented
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when a draw completes
- collision  out  1  result flag; valid from done until the next accepted start
- clear  in  1  (CHIP8_FB_CLEAR_EN only) screen-clear request

## Operation
- States: IDLE, ROW_REQ, ROW_WAIT, PIX_RD, PIX_WR, DONE (plus CLR with the macro).
- IDLE, start=1, n≠0: latch x, y, n, i_addr; clear row, col and collision; go to ROW_REQ.
- IDLE, start=1, n=0: clear collision; go directly to DONE.
- ROW_REQ: mem_addr = i_addr + row (12-bit wrap), mem_rd=1; go to ROW_WAIT.
- ROW_WAIT: load mem_readdata into the row shift register; set col=0; go to PIX_RD.
- PIX_RD: evaluate the current bit, MSB first.
  - Bit=1: drive fb_addr_x = x+col (mod 64), fb_addr_y = y+row (mod 32), fb_WE=0; go to PIX_WR.
  - Bit=0: no framebuffer access; advance.
- PIX_WR: keep the same address; fb_WE=1, fb_writedata = ~fb_readdata; collision |= fb_readdata; advance.
- Advance:
  - col<7: col+1, go to PIX_RD.
  - col=7, row<n-1: row+1, go to ROW_REQ.
  - Otherwise: go to DONE.
- DONE: done=1 for one cycle; return to IDLE.
- Coordinates wrap rather than clip. Wrap comes from native 6-bit and 5-bit adder overflow.
- start while busy is ignored. No queuing.
- Asynchronous reset_n low: state→IDLE; all outputs and collision→0. A partially drawn sprite stays in the framebuffer.
- Reset values: mem_addr=0, mem_rd=0, fb_addr_x=0, fb_addr_y=0, fb_writedata=0, fb_WE=0, busy=0, done=0, collision=0.

## Timing
- fb_*, mem_* and done are decoded from registered state. fb_writedata is combinational from fb_readdata in PIX_WR.
- Row cost: 2 cycles (ROW_REQ, ROW_WAIT) + 8 + number of set bits in the row.
- done asserts in cycle 1 + Σ(10 + ones_r), counting the first cycle after the start edge as cycle 1.
- n=0: done asserts in cycle 1.
- Throughput: a new start is accepted in the IDLE cycle right after DONE.

## Configuration
- CHIP8_FB_CLEAR_EN defined:
  - Adds the clear input and the CLR state (CLS instruction).
  - In IDLE, clear has priority over start.
  - CLR writes 0 to all 2048 pixels, one per cycle, y-major (x fastest), with fb_WE=1. It then enters DONE with collision=0.
  - Total: 2048 write cycles + DONE.
- CHIP8_FB_CLEAR_EN undefined: no clear port and no CLR state; CPU clears the screen by other means.

## Structure
- Package chip8_fb_pkg:
  - FB_WIDTH=64, FB_HEIGHT=32, SPRITE_W=8.
  - fb_x_t (6-bit) and fb_y_t (5-bit) typedefs.
  - drawer_state_t enum.
- No sub-module: a single FSM plus the row shift register, row/col counters and collision register.

## Test plan
- Empty fb, x=0, y=0, n=1, byte 0x80 → one write to (0,0) with data 1; collision=0; done in cycle 12.
- Repeat the same draw → pixel (0,0) written 0; collision=1.
- x=62, y=31, n=2, bytes 0xF0,0xF0 → writes to columns 62,63,0,1 on rows 31 and 0; collision=0.
- n=0 → done in cycle 1; no mem_rd, no fb_WE; collision=0.
- start reasserted while busy, then reset_n pulsed low mid-row → second start ignored; all outputs 0 immediately; next start draws normally.
- CHIP8_FB_CLEAR_EN: clear and start together in IDLE → 2048 zero writes (0,0)…(63,31), then done; start ignored.

Source files
------------

// File: rtl/chip8_fb_pkg.sv
// Shared framebuffer geometry, coordinate types and draw-engine state encoding.
// CHIP8_FB_CLEAR_EN adds the CLR state used by the screen-clear path.
package chip8_fb_pkg;

  localparam int FB_WIDTH   = 64;
  localparam int FB_HEIGHT  = 32;
  localparam int SPRITE_W   = 8;
  localparam int FB_PIXELS  = FB_WIDTH * FB_HEIGHT;

  typedef logic [5:0] fb_x_t;
  typedef logic [4:0] fb_y_t;

  typedef enum logic [2:0] {
    IDLE,
    ROW_REQ,
    ROW_WAIT,
    PIX_RD,
    PIX_WR,
    DONE
`ifdef CHIP8_FB_CLEAR_EN
    ,
    CLR
`endif
  } drawer_state_t;

endpackage

// File: rtl/chip8_sprite_drawer.sv
// DXYN draw engine: fetches sprite rows and XORs set bits into the framebuffer by read-modify-write.
// CHIP8_FB_CLEAR_EN adds the clear input and a full-screen zero-fill (CLS).
module chip8_sprite_drawer
  import chip8_fb_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [5:0]  x,
  input  logic [4:0]  y,
  input  logic [3:0]  n,
  input  logic [11:0] i_addr,
  output logic [11:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_readdata,
  output logic [5:0]  fb_addr_x,
  output logic [4:0]  fb_addr_y,
  output logic        fb_writedata,
  output logic        fb_WE,
  input  logic        fb_readdata,
`ifdef CHIP8_FB_CLEAR_EN
  input  logic        clear,
`endif
  output logic        busy,
  output logic        done,
  output logic        collision
);

  localparam logic [2:0] LAST_COL = 3'(SPRITE_W - 1);

  drawer_state_t state_q, state_d;
  fb_x_t         x_q, x_d;
  fb_y_t         y_q, y_d;
  logic [3:0]    n_q, n_d;
  logic [11:0]   base_q, base_d;
  logic [3:0]    row_q, row_d;
  logic [2:0]    col_q, col_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          collision_q, collision_d;
`ifdef CHIP8_FB_CLEAR_EN
  logic [10:0]   clr_cnt_q, clr_cnt_d;
`endif

  logic          do_advance;
  logic          more_rows;
  fb_x_t         pix_x;
  fb_y_t         pix_y;

  // Native adder overflow gives the modulo-64/32 wrap of sprite coordinates.
  assign pix_x     = x_q + fb_x_t'(col_q);
  assign pix_y     = y_q + fb_y_t'(row_q);
  assign more_rows = ({1'b0, row_q} + 5'd1) < {1'b0, n_q};

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    n_d         = n_q;
    base_d      = base_q;
    row_d       = row_q;
    col_d       = col_q;
    shreg_d     = shreg_q;
    collision_d = collision_q;
    do_advance  = 1'b0;
`ifdef CHIP8_FB_CLEAR_EN
    clr_cnt_d   = clr_cnt_q;
`endif

    case (state_q)
      IDLE: begin
`ifdef CHIP8_FB_CLEAR_EN
        if (clear) begin
          clr_cnt_d   = '0;
          collision_d = 1'b0;
          state_d     = CLR;
        end else
`endif
        if (start) begin
          collision_d = 1'b0;
          if (n != 4'd0) begin
            x_d     = x;
            y_d     = y;
            n_d     = n;
            base_d  = i_addr;
            row_d   = '0;
            col_d   = '0;
            state_d = ROW_REQ;
          end else begin
            state_d = DONE;
          end
        end
      end
      ROW_REQ:  state_d = ROW_WAIT;
      ROW_WAIT: begin
        shreg_d = mem_readdata;
        col_d   = '0;
        state_d = PIX_RD;
      end
      PIX_RD: begin
        if (shreg_q[7]) state_d = PIX_WR;
        else            do_advance = 1'b1;
      end
      PIX_WR: begin
        collision_d = collision_q | fb_readdata;
        do_advance  = 1'b1;
      end
      DONE:     state_d = IDLE;
`ifdef CHIP8_FB_CLEAR_EN
      CLR: begin
        clr_cnt_d = clr_cnt_q + 11'd1;
        if (clr_cnt_q == 11'(FB_PIXELS - 1)) state_d = DONE;
      end
`endif
      default:  state_d = IDLE;
    endcase

    if (do_advance) begin
      if (col_q != LAST_COL) begin
        col_d   = col_q + 3'd1;
        shreg_d = {shreg_q[6:0], 1'b0};
        state_d = PIX_RD;
      end else if (more_rows) begin
        row_d   = row_q + 4'd1;
        state_d = ROW_REQ;
      end else begin
        state_d = DONE;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      n_q         <= '0;
      base_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      shreg_q     <= '0;
      collision_q <= 1'b0;
`ifdef CHIP8_FB_CLEAR_EN
      clr_cnt_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      n_q         <= n_d;
      base_q      <= base_d;
      row_q       <= row_d;
      col_q       <= col_d;
      shreg_q     <= shreg_d;
      collision_q <= collision_d;
`ifdef CHIP8_FB_CLEAR_EN
      clr_cnt_q   <= clr_cnt_d;
`endif
    end
  end

  // Bus outputs are decoded from state so that reset forces them low immediately.
  always_comb begin
    mem_addr     = '0;
    mem_rd       = 1'b0;
    fb_addr_x    = '0;
    fb_addr_y    = '0;
    fb_writedata = 1'b0;
    fb_WE        = 1'b0;
    case (state_q)
      ROW_REQ: begin
        mem_addr = base_q + {8'd0, row_q};
        mem_rd   = 1'b1;
      end
      PIX_RD: begin
        if (shreg_q[7]) begin
          fb_addr_x = pix_x;
          fb_addr_y = pix_y;
        end
      end
      PIX_WR: begin
        fb_addr_x    = pix_x;
        fb_addr_y    = pix_y;
        fb_writedata = ~fb_readdata;
        fb_WE        = 1'b1;
      end
`ifdef CHIP8_FB_CLEAR_EN
      CLR: begin
        fb_addr_x = clr_cnt_q[5:0];
        fb_addr_y = clr_cnt_q[10:6];
        fb_WE     = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign busy      = (state_q != IDLE);
  assign done      = (state_q == DONE);
  assign collision = collision_q;

endmodule

// File: tb/tb_chip8_sprite_drawer.sv
// Self-checking bench for chip8_sprite_drawer: random DXYN draws against a pixel-level XOR model.
// Exercises the clear path when CHIP8_FB_CLEAR_EN is defined.
module tb_chip8_sprite_drawer;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  x = '0;
  logic [4:0]  y = '0;
  logic [3:0]  n = '0;
  logic [11:0] i_addr = '0;
  logic [11:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_readdata = '0;
  logic [5:0]  fb_addr_x;
  logic [4:0]  fb_addr_y;
  logic        fb_writedata;
  logic        fb_WE;
  logic        fb_readdata = 1'b0;
  logic        busy;
  logic        done;
  logic        collision;
`ifdef CHIP8_FB_CLEAR_EN
  logic        clear = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  logic [7:0]  mem [4096];
  bit          fbm [32][64];
  bit          ref_fb [32][64];
  logic [11:0] wlog [$];
  int          rd_cnt = 0;

  chip8_sprite_drawer dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .x            (x),
    .y            (y),
    .n            (n),
    .i_addr       (i_addr),
    .mem_addr     (mem_addr),
    .mem_rd       (mem_rd),
    .mem_readdata (mem_readdata),
    .fb_addr_x    (fb_addr_x),
    .fb_addr_y    (fb_addr_y),
    .fb_writedata (fb_writedata),
    .fb_WE        (fb_WE),
    .fb_readdata  (fb_readdata),
`ifdef CHIP8_FB_CLEAR_EN
    .clear        (clear),
`endif
    .busy         (busy),
    .done         (done),
    .collision    (collision)
  );

  always #5 clk = ~clk;

  // Framebuffer and main memory: one-cycle read latency, write on the clock edge.
  always @(posedge clk) begin
    if (fb_WE) begin
      fbm[fb_addr_y][fb_addr_x] <= fb_writedata;
      wlog.push_back({fb_addr_y, fb_addr_x, fb_writedata});
    end
    fb_readdata <= fbm[fb_addr_y][fb_addr_x];
    if (mem_rd) begin
      mem_readdata <= mem[mem_addr];
      rd_cnt <= rd_cnt + 1;
    end
  end

  task automatic check_fb_matches(input string tag);
    int bad = 0;
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 64; c++)
        if (fbm[r][c] !== ref_fb[r][c]) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL %s_fb_image got=%0d differing pixels exp=0", tag, bad);
    end
  endtask

  // One DXYN draw; inject>0 pulses an extra start at that cycle while busy.
  task automatic draw(input logic [5:0] dx, input logic [4:0] dy, input logic [3:0] dn,
                      input logic [11:0] da, input int inject, input string tag);
    logic [11:0] exp_w [$];
    int          exp_cyc = 1;
    bit          exp_coll = 0;
    int          w0;
    int          r0;
    int          cyc;
    int          ones;
    bit          ok;
    logic [7:0]  b;
    logic [11:0] a;
    logic [5:0]  px;
    logic [4:0]  py;
    bit          old;

    for (int r = 0; r < int'(dn); r++) begin
      a = da + 12'(r);
      b = mem[a];
      ones = 0;
      for (int c = 0; c < 8; c++) begin
        if (b[7-c]) begin
          px = dx + 6'(c);
          py = dy + 5'(r);
          old = ref_fb[py][px];
          exp_coll |= old;
          exp_w.push_back({py, px, ~old});
          ref_fb[py][px] = ~old;
          ones++;
        end
      end
      exp_cyc += 10 + ones;
    end

    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL %s_idle_before_start got=%b exp=0", tag, busy);
    end
    w0 = wlog.size();
    r0 = rd_cnt;
    x = dx; y = dy; n = dn; i_addr = da; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 400) begin
      if (cyc == inject) begin
        start = 1'b1; x = ~dx; n = 4'd1; i_addr = ~da;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;

    checks++;
    if (done !== 1'b1 || cyc != exp_cyc) begin
      failures++;
      $display("FAIL %s_done_cycle got=%0d (done=%b) exp=%0d", tag, cyc, done, exp_cyc);
    end
    checks++;
    if (collision !== exp_coll) begin
      failures++;
      $display("FAIL %s_collision got=%b exp=%b", tag, collision, exp_coll);
    end
    checks++;
    if (rd_cnt - r0 != int'(dn)) begin
      failures++;
      $display("FAIL %s_mem_reads got=%0d exp=%0d", tag, rd_cnt - r0, dn);
    end
    ok = (wlog.size() - w0 == exp_w.size());
    if (ok)
      foreach (exp_w[k])
        if (wlog[w0 + k] !== exp_w[k]) ok = 0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s_write_seq got=%0d writes exp=%0d writes (or order/data differs)",
               tag, wlog.size() - w0, exp_w.size());
    end
    check_fb_matches(tag);
    $display("draw %s x=%0d y=%0d n=%0d i=%03h done_cycle=%0d collision=%b writes=%0d",
             tag, dx, dy, dn, da, cyc, collision, wlog.size() - w0);
  endtask

  task automatic check_outputs_zero(input string tag);
    logic [29:0] outs;
    outs = {mem_addr, mem_rd, fb_addr_x, fb_addr_y, fb_writedata, fb_WE, busy, done, collision};
    checks++;
    if (outs !== '0) begin
      failures++;
      $display("FAIL %s got=%h exp=0", tag, outs);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_outputs_zero("reset_outputs");
    reset_n = 1'b1;
    @(negedge clk);
    check_outputs_zero("post_reset_idle");
    $display("reset outputs checked");
  endtask

  task automatic test_single_pixel();
    mem[12'h200] = 8'h80;
    draw(6'd0, 5'd0, 4'd1, 12'h200, -1, "pixel_set");
    draw(6'd0, 5'd0, 4'd1, 12'h200, -1, "pixel_clear");
  endtask

  task automatic test_n_zero();
    draw(6'd7, 5'd3, 4'd0, 12'h200, -1, "n_zero");
  endtask

  task automatic test_wrap();
    mem[12'h300] = 8'hF0;
    mem[12'h301] = 8'hF0;
    draw(6'd62, 5'd31, 4'd2, 12'h300, -1, "coord_wrap");
    mem[12'hFFF] = 8'($urandom);
    mem[12'h000] = 8'($urandom);
    draw(6'($urandom), 5'($urandom), 4'd2, 12'hFFF, -1, "addr_wrap");
  endtask

  task automatic test_busy_ignore();
    int extra;
    mem[12'h310] = 8'hA5;
    mem[12'h311] = 8'h3C;
    draw(6'd10, 5'd3, 4'd2, 12'h310, 4, "busy_start");
    extra = wlog.size();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy !== 1'b0) extra = -1;
    end
    checks++;
    if (extra != wlog.size()) begin
      failures++;
      $display("FAIL busy_start_ignored got=%0d exp=%0d (busy or writes after done)",
               extra, wlog.size());
    end
    $display("idle after ignored start: writes=%0d", wlog.size());
  endtask

  task automatic test_reset_mid();
    mem[12'h320] = 8'hFF;
    mem[12'h321] = 8'hFF;
    mem[12'h322] = 8'hFF;
    draw(6'd5, 5'd5, 4'd1, 12'h320, -1, "pre_reset");
    @(negedge clk);
    x = 6'd5; y = 5'd5; n = 4'd3; i_addr = 12'h320; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (fb_WE !== 1'b1 || collision !== 1'b1) begin
      failures++;
      $display("FAIL mid_draw_state got=we%b/coll%b exp=we1/coll1", fb_WE, collision);
    end
    reset_n = 1'b0;
    #1;
    check_outputs_zero("async_reset_outputs");
    @(negedge clk);
    reset_n = 1'b1;
    checks++;
    if (fbm[5][5] !== 1'b0 || fbm[5][6] !== 1'b1) begin
      failures++;
      $display("FAIL partial_sprite got=%b%b exp=01", fbm[5][5], fbm[5][6]);
    end
    $display("reset mid-row: partial sprite kept");
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 64; c++) ref_fb[r][c] = fbm[r][c];
    draw(6'd5, 5'd5, 4'd3, 12'h320, -1, "after_reset");
  endtask

  task automatic test_back_to_back();
    logic [11:0] a;
    logic [3:0]  dn;
    for (int t = 0; t < 16; t++) begin
      a  = 12'($urandom);
      dn = 4'($urandom_range(0, 15));
      for (int r = 0; r < 15; r++) mem[a + 12'(r)] = 8'($urandom);
      draw(6'($urandom), 5'($urandom), dn, a, -1, $sformatf("rand%0d", t));
    end
  endtask

`ifdef CHIP8_FB_CLEAR_EN
  task automatic test_clear();
    int  w0;
    int  cyc;
    bit  ok;
    w0 = wlog.size();
    @(negedge clk);
    clear = 1'b1; start = 1'b1; n = 4'd1; x = 6'd3; i_addr = 12'h200;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0; start = 1'b0;
    cyc = 1;
    while (done !== 1'b1 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    checks++;
    if (done !== 1'b1 || cyc != 2049) begin
      failures++;
      $display("FAIL clear_done_cycle got=%0d exp=2049", cyc);
    end
    checks++;
    if (collision !== 1'b0) begin
      failures++;
      $display("FAIL clear_collision got=%b exp=0", collision);
    end
    ok = (wlog.size() - w0 == 2048);
    if (ok)
      for (int k = 0; k < 2048; k++)
        if (wlog[w0 + k] !== {5'(k / 64), 6'(k % 64), 1'b0}) ok = 0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL clear_write_seq got=%0d writes exp=2048 in y-major order", wlog.size() - w0);
    end
    for (int r = 0; r < 32; r++)
      for (int c = 0; c < 64; c++) ref_fb[r][c] = 1'b0;
    check_fb_matches("clear");
    $display("clear: done_cycle=%0d writes=%0d", cyc, wlog.size() - w0);
  endtask
`endif

  initial begin
    for (int k = 0; k < 4096; k++) mem[k] = 8'h00;
    test_reset();
    test_single_pixel();
    test_n_zero();
    test_wrap();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
`ifdef CHIP8_FB_CLEAR_EN
    test_clear();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
